alu_req_arbiter: RTL
====================

# alu_req_arbiter

Round-robin arbiter and sequencer that shares one registered 64-bit ALU instance (`alu_64bit`) between NREQ requesters. It accepts one operation at a time over per-requester valid/ready handshakes, drives the ALU's enable/operand/select inputs, waits out the ALU latency, and returns the captured result on a single tagged response channel. Zero and sign are derived locally from the captured result; the ALU's own registered flags are not used.

## Interface
- NREQ, 4, number of requesters (2..8)
- ALU_LAT, 1, cycles from the ALU enable cycle to its result being valid on alu_out
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  request pending, one bit per requester
- req_ready  output  NREQ  one-hot grant; the handshake completes when req_valid[i] && req_ready[i]
- req_a  input  NREQ*64  operand A, requester i at [64*i +: 64]
- req_b  input  NREQ*64  operand B, same packing
- req_sel  input  NREQ*4  ALU opcode, requester i at [4*i +: 4]
- alu_enable  output  1  ALU enable strobe
- alu_a, alu_b  output  64  registered operands to the ALU
- alu_sel  output  4  registered opcode to the ALU
- alu_out  input  64  ALU result
- alu_carryout, alu_overflow  input  1  ALU carry and overflow
- resp_valid  output  1  response valid
- resp_ready  input  1  downstream accepts the response
- resp_id  output  $clog2(NREQ)  index of the originating requester
- resp_result  output  64  captured result
- resp_carry, resp_ovf  output  1  captured carry and overflow
- resp_zero  output  1  resp_result == 0
- resp_sign  output  1  resp_result[63]
- resp_err  output  1  request rejected (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, grant the first set bit searching upward from ptr, wrapping at NREQ.
  - req_ready is combinational, asserted only for the granted index, and only in IDLE.
  - On the handshake: latch A, B, sel and the index into alu_a, alu_b, alu_sel and resp_id; set ptr = grant+1 mod NREQ; go to ISSUE.
- **ISSUE**: alu_enable=1 for exactly one cycle; go to WAIT.
- **WAIT**
  - Lasts ALU_LAT cycles, counted by an internal counter.
  - In the last WAIT cycle, capture alu_out, alu_carryout and alu_overflow, and compute zero and sign; go to RESP.
- **RESP**
  - resp_valid=1, and all resp_* outputs are held stable.
  - On resp_ready, go to IDLE.
  - No new grant is made while in RESP.
- alu_a, alu_b and alu_sel hold their last values outside ISSUE. alu_enable is 0 in every state except ISSUE.
- Requests that are not granted must be held by the requester; the arbiter never drops them.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.

## Timing
- Reset (rst high at a clock edge):
  - state=IDLE, ptr=0, WAIT counter=0.
  - alu_enable=0; alu_a, alu_b, alu_sel=0.
  - resp_valid=0; all resp_* outputs=0.
  - req_ready=0 while rst is high.
- Reset mid-operation (ISSUE, WAIT or RESP) aborts the operation; the result is discarded and no response is emitted.
- Latency, with the handshake at cycle T:
  - alu_enable high at T+1.
  - Capture at T+1+ALU_LAT.
  - resp_valid from T+2+ALU_LAT.
  - The earliest next grant is the cycle after the resp handshake.
- Minimum spacing between grants is ALU_LAT+3 cycles.
- A requester that deasserts req_valid in IDLE loses its grant that same cycle; the grant moves combinationally to the next valid requester.

## Configuration
- Macro: ALU_REQ_ARB_DIV_GUARD_EN.
- Defined:
  - A request with sel=4'b1110 and B==0 is accepted normally but never issued: IDLE goes directly to RESP on the next cycle and alu_enable stays 0.
  - The response has resp_err=1, resp_result=0, resp_zero=1, resp_carry=resp_ovf=resp_sign=0.
- Not defined:
  - resp_err is tied to 0, and every request is issued to the ALU.
  - A divide by zero returns the ALU's sentinel value 64'h4521457896541234.

## Test plan
- After reset, requester 1 sends A=5, B=3, sel=0000 with ALU_LAT=1 -> req_ready[1] at T, alu_enable only at T+1, resp_valid at T+3 with id=1, result=8, zero=0, carry=0.
- All 4 requesters hold req_valid for 8 transactions with resp_ready=1 -> grant order 0,1,2,3,0,1,2,3; grants spaced 4 cycles apart.
- resp_ready held low for 5 cycles during RESP while other requesters are valid -> resp_* stable, req_ready=0 throughout, next grant the cycle after resp_ready rises.
- Subtraction (sel=0001) -> 5-5 gives result 0 with zero=1; 0-1 gives all-ones result with carry=1, sign=1.
- sel=1110, A=10, B=0 -> with the macro: resp_err=1, result 0, resp_valid 1 cycle after accept, alu_enable never asserted. Without the macro: result 64'h4521457896541234, err=0.
- rst pulsed during WAIT -> next cycle resp_valid=0 and alu_enable=0, no response ever emitted, and the next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter/sequencer sharing one registered 64-bit ALU
//
// Purpose: accepts one ALU operation at a time from NREQ requesters (round-robin
// from ptr), issues it to an external registered ALU, waits ALU_LAT cycles,
// captures the result and returns it on a single tagged response channel.
// Zero/sign are derived locally from the captured result.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b, req_sel         packed operands/opcode, requester i at [64*i +: 64] / [4*i +: 4]
//   alu_enable, alu_a/b/sel       registered drive to the ALU (enable only in ISSUE)
//   alu_out/carryout/overflow     ALU result inputs
//   resp_valid/resp_ready         response handshake
//   resp_id, resp_result          originating requester and captured result
//   resp_carry/ovf/zero/sign/err  captured flags, locally derived flags, rejection flag
//
// Optional feature macro: ALU_REQ_ARB_DIV_GUARD_EN
//   defined   : divide (sel=4'b1110) by zero is answered directly with resp_err=1
//   undefined : every request goes to the ALU, resp_err stays 0

module alu_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*64-1:0]      req_a,
    input  logic [NREQ*64-1:0]      req_b,
    input  logic [NREQ*4-1:0]       req_sel,
    output logic                    alu_enable,
    output logic [63:0]             alu_a,
    output logic [63:0]             alu_b,
    output logic [3:0]              alu_sel,
    input  logic [63:0]             alu_out,
    input  logic                    alu_carryout,
    input  logic                    alu_overflow,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [63:0]             resp_result,
    output logic                    resp_carry,
    output logic                    resp_ovf,
    output logic                    resp_zero,
    output logic                    resp_sign,
    output logic                    resp_err
);

    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;
    localparam int CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(ALU_LAT - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    alu_a_q, alu_a_d;
    logic [63:0]    alu_b_q, alu_b_d;
    logic [3:0]     alu_sel_q, alu_sel_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [63:0]    resp_result_q, resp_result_d;
    logic           resp_carry_q, resp_carry_d;
    logic           resp_ovf_q, resp_ovf_d;
    logic           resp_zero_q, resp_zero_d;
    logic           resp_sign_q, resp_sign_d;
    logic           resp_err_q, resp_err_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic           accept;
    logic [63:0]    gnt_a;
    logic [63:0]    gnt_b;
    logic [3:0]     gnt_sel;

    // First valid requester at or above ptr, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + IDW1'(k);
            if (cand >= IDW1'(NREQ)) begin
                cand = cand - IDW1'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // Grant is offered only while idle and out of reset; a withdrawn request
    // drops out of the search above in the same cycle.
    assign accept  = (state_q == ST_IDLE) && gnt_found && !rst;
    assign gnt_a   = req_a[64*gnt_idx +: 64];
    assign gnt_b   = req_b[64*gnt_idx +: 64];
    assign gnt_sel = req_sel[4*gnt_idx +: 4];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        resp_ovf_d    = resp_ovf_q;
        resp_zero_d   = resp_zero_q;
        resp_sign_d   = resp_sign_q;
        resp_err_d    = resp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d   = gnt_a;
                    alu_b_d   = gnt_b;
                    alu_sel_d = gnt_sel;
                    resp_id_d = gnt_idx;
                    ptr_d     = (gnt_idx == ID_LAST) ? '0 : gnt_idx + IDW'(1);
`ifdef ALU_REQ_ARB_DIV_GUARD_EN
                    // Divide by zero never reaches the ALU; answer with an error.
                    if (gnt_sel == 4'b1110 && gnt_b == 64'd0) begin
                        state_d       = ST_RESP;
                        resp_result_d = 64'd0;
                        resp_carry_d  = 1'b0;
                        resp_ovf_d    = 1'b0;
                        resp_zero_d   = 1'b1;
                        resp_sign_d   = 1'b0;
                        resp_err_d    = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    resp_result_d = alu_out;
                    resp_carry_d  = alu_carryout;
                    resp_ovf_d    = alu_overflow;
                    resp_zero_d   = (alu_out == 64'd0);
                    resp_sign_d   = alu_out[63];
                    resp_err_d    = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp_zero_q   <= 1'b0;
            resp_sign_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_zero_q   <= resp_zero_d;
            resp_sign_q   <= resp_sign_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign alu_enable  = (state_q == ST_ISSUE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_ovf    = resp_ovf_q;
    assign resp_zero   = resp_zero_q;
    assign resp_sign   = resp_sign_q;
    assign resp_err    = resp_err_q;

endmodule
